// File: rtl/prim_reqack_initiator_if.sv
// REQ/ACK port pair between the initiator and the two-phase CDC synchronizer.
// The initiator drives req_o; the synchronizer returns a single-cycle ack_i.
interface prim_reqack_initiator_if;
  logic req_o;
  logic ack_i;

  modport master (output req_o, input ack_i);
  modport slave  (input req_o, output ack_i);
endinterface

// File: rtl/prim_reqack_initiator.sv
// Turns source-domain event pulses into REQ/ACK transactions; REQ is registered and rises the cycle after an enabled event.
// Backpressure: events queue in a saturating pending counter while REQ waits for ACK; REQ never drops without ACK.
module prim_reqack_initiator #(
  parameter int CntW          = 4,
  parameter int TimeoutW      = 8,
  parameter int TimeoutCycles = 200
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          evt_i,
  input  logic                          clr_i,
  prim_reqack_initiator_if.master       sync,
  output logic [CntW-1:0]               pending_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic                          timeout_o,
  output logic                          err_ack_o
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [CntW-1:0]     PendMax  = {CntW{1'b1}};
  localparam logic [TimeoutW-1:0] TmoMax   = {TimeoutW{1'b1}};
  localparam logic [TimeoutW-1:0] TmoLimit = TimeoutW'(TimeoutCycles);
  localparam bit                  TmoEn    = (TimeoutCycles != 0);

  state_e              state_q, state_d;
  logic [CntW-1:0]     pending_q, pending_d;
  logic [TimeoutW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                overflow_q, overflow_d;
  logic                timeout_q, timeout_d;
  logic                err_ack_q, err_ack_d;
  logic                req;
  logic                hs;
  logic                ovf_set;
  logic                tmo_set;
  logic                err_set;

  assign req     = (state_q == REQ);
  assign hs      = req & sync.ack_i;
  assign ovf_set = evt_i & ~hs & (pending_q == PendMax);
  assign err_set = sync.ack_i & ~req;

  // Pending counter: an event that coincides with a handshake replaces the completed one.
  always_comb begin
    pending_d = pending_q;
    if (evt_i && !hs) begin
      if (pending_q != PendMax) pending_d = pending_q + CntW'(1);
    end else if (!evt_i && hs) begin
      if (pending_q != '0) pending_d = pending_q - CntW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en_i && (pending_q != '0 || evt_i)) state_d = REQ;
      REQ:  if (hs && !(en_i && pending_d != '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outstanding-cycle counter restarts with each new transaction, including back-to-back ones.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!req || hs) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TmoMax) begin
      tmo_cnt_d = tmo_cnt_q + TimeoutW'(1);
    end
  end

  assign tmo_set = TmoEn && req && !hs && (tmo_cnt_d == TmoLimit);

  // Sticky flags: a set condition in the same cycle as clr_i wins.
  always_comb begin
    overflow_d = ovf_set | (overflow_q & ~clr_i);
    timeout_d  = tmo_set | (timeout_q  & ~clr_i);
    err_ack_d  = err_set | (err_ack_q  & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      tmo_cnt_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      err_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      tmo_cnt_q  <= tmo_cnt_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      err_ack_q  <= err_ack_d;
    end
  end

  assign sync.req_o = req;
  assign busy_o     = req;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;
  assign timeout_o  = timeout_q;
  assign err_ack_o  = err_ack_q;

endmodule

// File: tb/tb_prim_reqack_initiator.sv
// Directed bench for prim_reqack_initiator built with CntW=2 and TimeoutCycles=4.
module tb_prim_reqack_initiator;

  logic       clk;
  logic       rst_ni;
  logic       en;
  logic       evt;
  logic       clr;
  logic [1:0] pending;
  logic       busy;
  logic       ovf;
  logic       tmo;
  logic       err;

  int n_checks;
  int n_fail;

  prim_reqack_initiator_if sync_if ();

  prim_reqack_initiator #(
    .CntW         (2),
    .TimeoutW     (8),
    .TimeoutCycles(4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .en_i      (en),
    .evt_i     (evt),
    .clr_i     (clr),
    .sync      (sync_if),
    .pending_o (pending),
    .busy_o    (busy),
    .overflow_o(ovf),
    .timeout_o (tmo),
    .err_ack_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs driven after this settle before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    en            = 1'b0;
    evt           = 1'b0;
    clr           = 1'b0;
    sync_if.ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (sync_if.req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", sync_if.req_o); end
    n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (pending !== 2'd0)       begin n_fail++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    n_checks++; if (ovf !== 1'b0)           begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    n_checks++; if (tmo !== 1'b0)           begin n_fail++; $display("FAIL reset_tmo got=%b exp=0", tmo); end
    n_checks++; if (err !== 1'b0)           begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_single_event();
    do_reset();
    en = 1'b1;
    evt = 1'b1;
    step();
    evt = 1'b0;
    n_checks++; if (sync_if.req_o !== 1'b1) begin n_fail++; $display("FAIL single_req_rise got=%b exp=1", sync_if.req_o); end
    n_checks++; if (pending !== 2'd1)       begin n_fail++; $display("FAIL single_pending got=%0d exp=1", pending); end
    n_checks++; if (busy !== 1'b1)          begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
    repeat (3) step();
    n_checks++; if (sync_if.req_o !== 1'b1) begin n_fail++; $display("FAIL single_req_hold got=%b exp=1", sync_if.req_o); end
    sync_if.ack_i = 1'b1;
    step();
    sync_if.ack_i = 1'b0;
    n_checks++; if (sync_if.req_o !== 1'b0) begin n_fail++; $display("FAIL single_req_fall got=%b exp=0", sync_if.req_o); end
    n_checks++; if (pending !== 2'd0)       begin n_fail++; $display("FAIL single_pending_done got=%0d exp=0", pending); end
  endtask

  task automatic test_burst();
    logic [1:0] exp_pend [3];
    logic       exp_req  [3];
    exp_pend = '{2'd2, 2'd1, 2'd0};
    exp_req  = '{1'b1, 1'b1, 1'b0};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      evt = 1'b1;
      step();
      n_checks++; if (sync_if.req_o !== 1'b1) begin n_fail++; $display("FAIL burst_req_evt%0d got=%b exp=1", i, sync_if.req_o); end
      n_checks++; if (pending !== 2'(i + 1))  begin n_fail++; $display("FAIL burst_pend_evt%0d got=%0d exp=%0d", i, pending, i + 1); end
    end
    evt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (sync_if.req_o !== 1'b1) begin n_fail++; $display("FAIL burst_req_wait%0d got=%b exp=1", i, sync_if.req_o); end
    end
    sync_if.ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (pending !== exp_pend[i])      begin n_fail++; $display("FAIL burst_pend_ack%0d got=%0d exp=%0d", i, pending, exp_pend[i]); end
      n_checks++; if (sync_if.req_o !== exp_req[i]) begin n_fail++; $display("FAIL burst_req_ack%0d got=%b exp=%b", i, sync_if.req_o, exp_req[i]); end
    end
    sync_if.ack_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic [1:0] exp_pend [5];
    logic       exp_ovf  [5];
    exp_pend = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    exp_ovf  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      evt = 1'b1;
      step();
      n_checks++; if (pending !== exp_pend[i]) begin n_fail++; $display("FAIL ovf_pend%0d got=%0d exp=%0d", i, pending, exp_pend[i]); end
      n_checks++; if (ovf !== exp_ovf[i])      begin n_fail++; $display("FAIL ovf_flag%0d got=%b exp=%b", i, ovf, exp_ovf[i]); end
      n_checks++; if (sync_if.req_o !== 1'b0)  begin n_fail++; $display("FAIL ovf_req%0d got=%b exp=0", i, sync_if.req_o); end
    end
    evt = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++; if (ovf !== 1'b0)     begin n_fail++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
    n_checks++; if (pending !== 2'd3) begin n_fail++; $display("FAIL ovf_clr_pend got=%0d exp=3", pending); end
  endtask

  task automatic test_timeout();
    do_reset();
    en = 1'b1;
    evt = 1'b1;
    step();
    evt = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_early%0d got=%b exp=0", i, tmo); end
    end
    step();
    n_checks++; if (tmo !== 1'b1)           begin n_fail++; $display("FAIL tmo_set got=%b exp=1", tmo); end
    n_checks++; if (sync_if.req_o !== 1'b1) begin n_fail++; $display("FAIL tmo_req_held got=%b exp=1", sync_if.req_o); end
    step();
    sync_if.ack_i = 1'b1;
    step();
    sync_if.ack_i = 1'b0;
    n_checks++; if (sync_if.req_o !== 1'b0) begin n_fail++; $display("FAIL tmo_ack_req got=%b exp=0", sync_if.req_o); end
    n_checks++; if (pending !== 2'd0)       begin n_fail++; $display("FAIL tmo_ack_pend got=%0d exp=0", pending); end
    n_checks++; if (tmo !== 1'b1)           begin n_fail++; $display("FAIL tmo_sticky got=%b exp=1", tmo); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_clr got=%b exp=0", tmo); end
  endtask

  task automatic test_err_ack();
    do_reset();
    en = 1'b0;
    evt = 1'b1;
    step();
    evt = 1'b0;
    sync_if.ack_i = 1'b1;
    step();
    sync_if.ack_i = 1'b0;
    n_checks++; if (err !== 1'b1)           begin n_fail++; $display("FAIL err_set got=%b exp=1", err); end
    n_checks++; if (pending !== 2'd1)       begin n_fail++; $display("FAIL err_pend got=%0d exp=1", pending); end
    n_checks++; if (sync_if.req_o !== 1'b0) begin n_fail++; $display("FAIL err_req got=%b exp=0", sync_if.req_o); end
    clr = 1'b1;
    step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr got=%b exp=0", err); end
    sync_if.ack_i = 1'b1;
    step();
    sync_if.ack_i = 1'b0;
    clr = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set_wins got=%b exp=1", err); end
  endtask

  task automatic test_evt_hs_then_reset();
    do_reset();
    en = 1'b1;
    evt = 1'b1;
    step();
    sync_if.ack_i = 1'b1;
    step();
    evt = 1'b0;
    sync_if.ack_i = 1'b0;
    n_checks++; if (pending !== 2'd1)       begin n_fail++; $display("FAIL evths_pend got=%0d exp=1", pending); end
    n_checks++; if (sync_if.req_o !== 1'b1) begin n_fail++; $display("FAIL evths_req got=%b exp=1", sync_if.req_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++; if (sync_if.req_o !== 1'b0) begin n_fail++; $display("FAIL arst_req got=%b exp=0", sync_if.req_o); end
    n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL arst_busy got=%b exp=0", busy); end
    n_checks++; if (pending !== 2'd0)       begin n_fail++; $display("FAIL arst_pend got=%0d exp=0", pending); end
    rst_ni = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_ni        = 1'b0;
    en            = 1'b0;
    evt           = 1'b0;
    clr           = 1'b0;
    sync_if.ack_i = 1'b0;
    test_reset();
    test_single_event();
    test_burst();
    test_overflow();
    test_timeout();
    test_err_ack();
    test_evt_hs_then_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
